// File: rtl/m_load_unit.sv
// Memory-stage load unit: word-aligned read via req/ack, then byte/half/word extract and sign/zero-extend.
// Latency: load at cycle 0, mem_req from cycle 1, RData_valid one cycle after mem_ack (min 3 cycles).
// Backpressure: stall held from the accepting IDLE cycle until the ack cycle; memory may hold off ack indefinitely.
//
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   req_valid, Instr, Addr - M-stage instruction and effective byte address
//   mem_req, mem_addr     - word-aligned read request to data memory
//   mem_rdata, mem_ack    - read data, valid only in the ack cycle
//   stall                 - freezes F/D/E/M while a load is outstanding
//   RData, RData_valid    - extended load result and its one-cycle strobe
//   AdEL                  - one-cycle misaligned-load strobe
module m_load_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] Instr,
    input  logic [31:0] Addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [31:0] RData,
    output logic        RData_valid,
    output logic        AdEL
);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] rdata_q, rdata_d;

    logic [5:0]  opcode;
    logic        is_load;
    logic        misaligned;
    logic        accept;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;

    // Only the opcode field matters here; the rest of the instruction is unused.
    logic        unused_instr;
    assign unused_instr = ^Instr[25:0];

    assign opcode = Instr[31:26];

    always_comb begin
        is_load = 1'b0;
        case (opcode)
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: is_load = req_valid;
            default:                             is_load = 1'b0;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (opcode)
            OP_LW:          misaligned = (Addr[1:0] != 2'b00);
            OP_LH, OP_LHU:  misaligned = Addr[0];
            default:        misaligned = 1'b0;
        endcase
    end

    // A new load is only looked at in IDLE; in DONE req_valid still shows
    // the instruction just serviced and must not be re-issued.
    assign accept = (state_q == IDLE) && is_load && !misaligned && !reset;

    // Extraction uses the offset latched at accept time, not the live Addr.
    always_comb begin
        sel_byte = mem_rdata[7:0];
        case (off_q)
            2'd0:    sel_byte = mem_rdata[7:0];
            2'd1:    sel_byte = mem_rdata[15:8];
            2'd2:    sel_byte = mem_rdata[23:16];
            default: sel_byte = mem_rdata[31:24];
        endcase
        sel_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        ext_data = mem_rdata;
        case (op_q)
            OP_LB:   ext_data = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  ext_data = {24'h0, sel_byte};
            OP_LH:   ext_data = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  ext_data = {16'h0, sel_half};
            default: ext_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        off_d      = off_q;
        mem_addr_d = mem_addr_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d       = opcode;
                    off_d      = Addr[1:0];
                    mem_addr_d = {Addr[31:2], 2'b00};
                    state_d    = REQ;
                end
            end
            REQ: begin
                // No timeout: memory latency is unbounded by design.
                if (mem_ack) begin
                    rdata_d = ext_data;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= 6'h0;
            off_q      <= 2'b00;
            mem_addr_q <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            off_q      <= off_d;
            mem_addr_q <= mem_addr_d;
            rdata_q    <= rdata_d;
        end
    end

    assign mem_req     = (state_q == REQ);
    assign mem_addr    = mem_addr_q;
    assign RData       = rdata_q;
    assign RData_valid = (state_q == DONE);
    // Stall must rise in the accepting cycle itself so M holds the load.
    assign stall       = accept || (state_q == REQ);
    assign AdEL        = (state_q == IDLE) && is_load && misaligned && !reset;

endmodule

// File: tb/tb_m_load_unit.sv
// Testbench for m_load_unit: directed loads with a scoreboard queue of expected responses.
// Latency and stall/mem_req timing checked by the stimulus process; results and AdEL by a negedge monitor.
// Memory ack delay is controlled per load; no backpressure beyond that.
module tb_m_load_unit;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] Instr;
    logic [31:0] Addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic [31:0] RData;
    logic        RData_valid;
    logic        AdEL;

    typedef struct {
        logic        is_adel;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rdata;

    m_load_unit dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .Instr       (Instr),
        .Addr        (Addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .stall       (stall),
        .RData       (RData),
        .RData_valid (RData_valid),
        .AdEL        (AdEL)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every result or AdEL strobe must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && (RData_valid || AdEL)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: RData_valid=%b AdEL=%b RData=%h at %0t",
                         RData_valid, AdEL, RData, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_adel) begin
                    if (!(AdEL === 1'b1 && RData_valid === 1'b0)) begin
                        errors++;
                        $display("FAIL adel_strobe: AdEL=%b RData_valid=%b expected AdEL only at %0t",
                                 AdEL, RData_valid, $time);
                    end
                end else begin
                    if (!(RData_valid === 1'b1 && AdEL === 1'b0 && RData === e.data)) begin
                        errors++;
                        $display("FAIL load_result: RData=%h valid=%b AdEL=%b expected %h at %0t",
                                 RData, RData_valid, AdEL, e.data, $time);
                    end
                end
            end
        end
    end

    // Aligned load with ack after k cycles of REQ (k>=1).
    task automatic do_load(input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input int k, input logic [31:0] exp);
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1;
        Instr     = {op, 26'h0};
        Addr      = addr;
        mem_ack   = 1'b0;
        e.is_adel = 1'b0;
        e.data    = exp;
        exp_q.push_back(e);
        @(negedge clk);
        check("stall_c0", {31'h0, stall}, 32'd1);
        check("mem_req_c0", {31'h0, mem_req}, 32'd0);
        for (int c = 1; c <= k; c++) begin
            @(posedge clk); #1;
            mem_ack   = (c == k);
            mem_rdata = (c == k) ? rdata : 32'h5A5A_A5A5;
            @(negedge clk);
            check("mem_req_wait", {31'h0, mem_req}, 32'd1);
            check("stall_wait", {31'h0, stall}, 32'd1);
            check("mem_addr", mem_addr, {addr[31:2], 2'b00});
        end
        // DONE cycle: req_valid still high and must be ignored.
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'hA5A5_5A5A;
        @(negedge clk);
        check("rdata_valid_k1", {31'h0, RData_valid}, 32'd1);
        check("stall_done", {31'h0, stall}, 32'd0);
        check("mem_req_done", {31'h0, mem_req}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("mem_req_idle", {31'h0, mem_req}, 32'd0);
        check("rdata_hold", RData, exp);
        last_rdata = exp;
    endtask

    // Misaligned load, optionally with a coincident ack that must be ignored.
    task automatic do_misaligned(input logic [5:0] op, input logic [31:0] addr, input logic ack);
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1;
        Instr     = {op, 26'h0};
        Addr      = addr;
        mem_ack   = ack;
        mem_rdata = 32'hCAFE_F00D;
        e.is_adel = 1'b1;
        e.data    = 32'h0;
        exp_q.push_back(e);
        @(negedge clk);
        check("adel_level", {31'h0, AdEL}, 32'd1);
        check("mis_stall", {31'h0, stall}, 32'd0);
        check("mis_mem_req", {31'h0, mem_req}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ack   = 1'b0;
        @(negedge clk);
        check("mis_mem_req_next", {31'h0, mem_req}, 32'd0);
        check("mis_rdata_kept", RData, last_rdata);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        Instr     = 32'h0;
        Addr      = 32'h0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        last_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mem_req", {31'h0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rdata", RData, 32'h0);
        check("rst_rdata_valid", {31'h0, RData_valid}, 32'd0);
        check("rst_adel", {31'h0, AdEL}, 32'd0);
        check("rst_stall", {31'h0, stall}, 32'd0);

        do_load(OP_LW,  32'h0000_1004, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
        do_load(OP_LB,  32'h0000_2003, 32'h80FF_1234, 3, 32'hFFFF_FF80);
        do_load(OP_LBU, 32'h0000_2003, 32'h80FF_1234, 3, 32'h0000_0080);
        do_load(OP_LB,  32'h0000_2001, 32'h80FF_1234, 2, 32'h0000_0012);
        do_load(OP_LB,  32'h0000_2002, 32'h80FF_1234, 1, 32'hFFFF_FFFF);
        do_load(OP_LBU, 32'h0000_2002, 32'h80FF_1234, 1, 32'h0000_00FF);
        do_load(OP_LBU, 32'h0000_2000, 32'h80FF_1234, 1, 32'h0000_0034);
        do_load(OP_LH,  32'h0000_3002, 32'h8001_7FFF, 2, 32'hFFFF_8001);
        do_load(OP_LHU, 32'h0000_3002, 32'h8001_7FFF, 2, 32'h0000_8001);
        do_load(OP_LH,  32'h0000_3000, 32'h8001_7FFF, 1, 32'h0000_7FFF);
        do_load(OP_LHU, 32'h0000_3000, 32'h8001_7FFF, 1, 32'h0000_7FFF);
        do_load(OP_LH,  32'h0000_3000, 32'h1234_F00F, 1, 32'hFFFF_F00F);

        do_misaligned(OP_LW,  32'h0000_4002, 1'b0);
        do_misaligned(OP_LH,  32'h0000_4001, 1'b0);
        do_misaligned(OP_LHU, 32'h0000_4003, 1'b1);
        do_misaligned(OP_LW,  32'h0000_4001, 1'b1);

        // Non-load opcode plus a spurious ack in IDLE: nothing happens.
        @(posedge clk); #1;
        req_valid = 1'b1;
        Instr     = {OP_SW, 26'h0};
        Addr      = 32'h0000_5000;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        @(negedge clk);
        check("sw_stall", {31'h0, stall}, 32'd0);
        check("sw_mem_req", {31'h0, mem_req}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ack   = 1'b0;
        @(negedge clk);
        check("sw_mem_req_next", {31'h0, mem_req}, 32'd0);
        check("sw_rdata_kept", RData, last_rdata);

        // Reset while in REQ, then a late ack.
        @(posedge clk); #1;
        req_valid = 1'b1;
        Instr     = {OP_LW, 26'h0};
        Addr      = 32'h0000_6008;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_mem_req", {31'h0, mem_req}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        check("midrst_mem_req", {31'h0, mem_req}, 32'd0);
        check("midrst_stall", {31'h0, stall}, 32'd0);
        check("midrst_rdata", RData, 32'h0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_valid", {31'h0, RData_valid}, 32'd0);
        check("late_ack_rdata", RData, 32'h0);
        check("late_ack_mem_req", {31'h0, mem_req}, 32'd0);
        last_rdata = 32'h0;

        // Recovery after reset.
        do_load(OP_LW, 32'h0000_7FFC, 32'h0BAD_F00D, 2, 32'h0BAD_F00D);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
